date_seg_encoder: RTL and testbench
===================================

Name: date_seg_encoder

Overview:
Converts a day-of-year count (1..366) into a month/day calendar date and drives four active-low seven-segment digit patterns, which feed the HEX displays of the date counter top level. Conversion is sequential. A month-walk FSM subtracts one month length per clock, then a tens-extraction loop splits the day into tens and ones. This is the encoding (writer) end of the HEX segment interface that the display checker decodes.

Parameters:
MAX_LEAP, 366, highest legal day_of_year when leap=1
MAX_NORM, 365, highest legal day_of_year when leap=0

Ports:
ADC_CLK_10  input  1  system clock; all state changes on its rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request strobe; sampled only in IDLE
day_of_year  input  9  unsigned day count; sampled with start
leap  input  1  1 = Feb has 29 days; sampled with start
busy  output  1  high while a conversion is in progress (not IDLE)
done  output  1  one-cycle pulse when the hex_* outputs update
err  output  1  high when the last request was out of range; held until the next accepted start
hex_day_ones  output  8  segment pattern for day ones digit (HEX0)
hex_day_tens  output  8  segment pattern for day tens digit (HEX1); blank when 0
hex_month_ones  output  8  segment pattern for month ones digit (HEX2)
hex_month_tens  output  8  segment pattern for month tens digit (HEX3); blank when 0

Behaviour:
- Clocking and reset: one clock, ADC_CLK_10. reset_n is asynchronous and active-low.
- Segment encoding is active-low, bit7 = decimal point, always 1:
  - 0=11000000, 1=11111001, 2=10100100, 3=10110000, 4=10011001
  - 5=10010010, 6=10000010, 7=11111000, 8=10000000, 9=10010000
  - blank=11111111, dash=10111111
- Reset (reset_n=0, any time, including mid-conversion): state forced to IDLE asynchronously.
  - All hex_* = 11111111; busy=0, done=0, err=0.
  - Internal remainder, month and tens registers cleared.
- FSM states: IDLE, CHECK, WALK, SPLIT.
  - IDLE: on the edge where start=1, capture day_of_year and leap, clear err, go to CHECK. start=0 stays in IDLE.
  - CHECK (1 cycle): request is illegal if day_of_year=0, or day_of_year>MAX_NORM with leap=0, or day_of_year>MAX_LEAP with leap=1.
    - Illegal: all four hex_* = dash, err=1, done=1, go to IDLE.
    - Legal: month=1, rem=day_of_year, go to WALK.
  - WALK (1 cycle per month): len = 31/28(29 if leap)/31/30/31/30/31/31/30/31/30/31 for months 1..12.
    - If rem > len: rem -= len, month += 1.
    - Else: tens=0, go to SPLIT.
  - SPLIT (1 cycle per ten):
    - If rem >= 10: rem -= 10, tens += 1.
    - Else, on this edge: hex_day_ones=enc(rem); hex_day_tens = blank if tens=0 else enc(tens); hex_month_tens = blank if month<10 else enc(1); hex_month_ones = enc(month mod 10); done=1; go to IDLE.
- Latency: done is high in the cycle after edge N, where N counts from the edge that samples start.
  - Legal request: N = 1 + month + day_tens + 1.
  - Illegal request: N = 1.
- done is high for exactly one cycle. hex_* and err hold their values until the next done or reset.
- All four hex_* outputs update on the same edge; no partial or intermediate values are ever visible.
- busy=1 in CHECK/WALK/SPLIT, 0 in IDLE. start while busy is ignored (not queued). Changes to day_of_year or leap after sampling have no effect.
- start asserted in the same cycle that done is high: accepted, because the FSM is already in IDLE.
- Widths: rem is 9 bits, month 4 bits, tens 2 bits. No arithmetic wraps: the month length check guarantees rem >= 1 on entry to SPLIT.

Test Plan:
- Reset then idle -> all hex_* = 11111111, busy=0, err=0.
- start, day_of_year=60, leap=0 -> Mar 1.
  - done high after edge 5.
  - hex_month_tens=11111111, hex_month_ones=10110000, hex_day_tens=11111111, hex_day_ones=11111001.
- start, day_of_year=60, leap=1 -> Feb 29.
  - done after edge 6.
  - hex_month_ones=10100100, hex_day_tens=10100100, hex_day_ones=10010000.
- start, day_of_year=366, leap=1 -> Dec 31.
  - done after edge 17.
  - hex_month_tens=11111001, hex_month_ones=10100100, hex_day_tens=10110000, hex_day_ones=11111001.
- start, 366 leap=0; then start, 0 leap=1 -> each: done after edge 1, err=1, all hex_* = 10111111. A following legal request (day 1) clears err and shows month 1, day 1.
- Mid-conversion events on a request for 300:
  - Pulse start with 1 at edge 3 -> ignored; result shows Oct 27.
  - Assert reset_n=0 at edge 6 of a repeat request -> outputs blank at once, no done.

Source files
------------

// File: rtl/date_seg_encoder.sv
// Day-of-year to month/day converter driving four active-low 7-seg digits.
// Ports: ADC_CLK_10, reset_n, start/day_of_year/leap in; busy/done/err, hex_* out.
module date_seg_encoder #(
  parameter int unsigned MAX_LEAP = 366,
  parameter int unsigned MAX_NORM = 365
) (
  input  logic       ADC_CLK_10,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] day_of_year,
  input  logic       leap,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] hex_day_ones,
  output logic [7:0] hex_day_tens,
  output logic [7:0] hex_month_ones,
  output logic [7:0] hex_month_tens
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] WALK  = 2'd2;
  localparam logic [1:0] SPLIT = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [8:0] MAX_L9 = 9'(MAX_LEAP);
  localparam logic [8:0] MAX_N9 = 9'(MAX_NORM);

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [8:0] month_len(
    input logic [3:0] m,
    input logic       lp
  );
    logic [8:0] l;
    case (m)
      4'd2:    l = lp ? 9'd29 : 9'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   l = 9'd30;
      default: l = 9'd31;
    endcase
    return l;
  endfunction

  logic [1:0] state;
  logic [8:0] rem;
  logic [3:0] month;
  logic [1:0] tens;
  logic       leap_q;

  logic       illegal;
  logic [8:0] cur_len;
  logic [3:0] month_ones;

  // The request is latched straight into rem, so CHECK validates rem.
  assign illegal = (rem == 9'd0)
                 || (!leap_q && rem > MAX_N9)
                 || ( leap_q && rem > MAX_L9);

  assign cur_len    = month_len(month, leap_q);
  assign month_ones = (month >= 4'd10) ? month - 4'd10 : month;
  assign busy       = (state != IDLE);

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rem            <= '0;
      month          <= '0;
      tens           <= '0;
      leap_q         <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      hex_day_ones   <= SEG_BLANK;
      hex_day_tens   <= SEG_BLANK;
      hex_month_ones <= SEG_BLANK;
      hex_month_tens <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem    <= day_of_year;
            leap_q <= leap;
            err    <= 1'b0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (illegal) begin
            hex_day_ones   <= SEG_DASH;
            hex_day_tens   <= SEG_DASH;
            hex_month_ones <= SEG_DASH;
            hex_month_tens <= SEG_DASH;
            err            <= 1'b1;
            done           <= 1'b1;
            state          <= IDLE;
          end else begin
            month <= 4'd1;
            state <= WALK;
          end
        end
        WALK: begin
          if (rem > cur_len) begin
            rem   <= rem - cur_len;
            month <= month + 4'd1;
          end else begin
            tens  <= '0;
            state <= SPLIT;
          end
        end
        SPLIT: begin
          if (rem >= 9'd10) begin
            rem  <= rem - 9'd10;
            tens <= tens + 2'd1;
          end else begin
            hex_day_ones   <= enc(rem[3:0]);
            hex_day_tens   <= (tens == 2'd0) ? SEG_BLANK
                                             : enc({2'b00, tens});
            hex_month_tens <= (month < 4'd10) ? SEG_BLANK
                                              : enc(4'd1);
            hex_month_ones <= enc(month_ones);
            done           <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_date_seg_encoder.sv
// Directed testbench for date_seg_encoder.
// Each scenario task drives a request and checks latency and digits inline.
module tb_date_seg_encoder;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [8:0] day_of_year;
  logic       leap;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] hex_day_ones;
  logic [7:0] hex_day_tens;
  logic [7:0] hex_month_ones;
  logic [7:0] hex_month_tens;

  int compared;
  int mismatched;

  date_seg_encoder dut (
    .ADC_CLK_10     (clk),
    .reset_n        (reset_n),
    .start          (start),
    .day_of_year    (day_of_year),
    .leap           (leap),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .hex_day_ones   (hex_day_ones),
    .hex_day_tens   (hex_day_tens),
    .hex_month_ones (hex_month_ones),
    .hex_month_tens (hex_month_tens)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hexes();
    return {hex_month_tens, hex_month_ones, hex_day_tens, hex_day_ones};
  endfunction

  // Drives one request; edge 0 samples start. n = edge after which done
  // was seen (-1 if never within the budget). Optionally pulses start
  // with day 1 at edge pulse_at while busy.
  task automatic run_req(
    input  logic [8:0] d,
    input  logic       lp,
    input  int         pulse_at,
    output int         n,
    output logic       busy0,
    output logic       done0
  );
    start       = 1'b1;
    day_of_year = d;
    leap        = lp;
    @(posedge clk);
    #1;
    start       = 1'b0;
    busy0       = busy;
    done0       = done;
    day_of_year = 9'd427;
    leap        = ~lp;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == pulse_at) begin
        start       = 1'b1;
        day_of_year = 9'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    start       = 1'b0;
    day_of_year = '0;
    leap        = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (hexes() !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("FAIL reset_hex got=%h want=ffffffff", hexes());
    end
    compared++;
    if ({busy, done, err} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, err});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, hexes()} !== {1'b0, 32'hFFFF_FFFF}) begin
      mismatched++;
      $display("FAIL idle_after_reset got=%b/%h want=0/ffffffff",
               busy, hexes());
    end
  endtask

  task automatic test_mar1();
    int n;
    logic b0, d0;
    @(negedge clk);
    run_req(9'd60, 1'b0, -1, n, b0, d0);
    compared++;
    if (b0 !== 1'b1) begin
      mismatched++;
      $display("FAIL mar1_busy got=%b want=1", b0);
    end
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL mar1_latency got=%0d want=5", n);
    end
    compared++;
    if (hexes() !== 32'hFFB0_FFF9 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL mar1_hex got=%h err=%b want=ffb0fff9 err=0",
               hexes(), err);
    end
    @(posedge clk);
    #1;
    compared++;
    if ({done, busy} !== 2'b00 || hexes() !== 32'hFFB0_FFF9) begin
      mismatched++;
      $display("FAIL mar1_hold got=%b%b/%h want=00/ffb0fff9",
               done, busy, hexes());
    end
  endtask

  task automatic test_feb29();
    int n;
    logic b0, d0;
    @(negedge clk);
    run_req(9'd60, 1'b1, -1, n, b0, d0);
    compared++;
    if (n !== 6) begin
      mismatched++;
      $display("FAIL feb29_latency got=%0d want=6", n);
    end
    compared++;
    if (hexes() !== 32'hFFA4_A490) begin
      mismatched++;
      $display("FAIL feb29_hex got=%h want=ffa4a490", hexes());
    end
  endtask

  task automatic test_dec31();
    int n;
    logic b0, d0;
    @(negedge clk);
    run_req(9'd366, 1'b1, -1, n, b0, d0);
    compared++;
    if (n !== 17) begin
      mismatched++;
      $display("FAIL dec31_latency got=%0d want=17", n);
    end
    compared++;
    if (hexes() !== 32'hF9A4_B0F9) begin
      mismatched++;
      $display("FAIL dec31_hex got=%h want=f9a4b0f9", hexes());
    end
  endtask

  task automatic test_illegal();
    int n;
    logic b0, d0;
    @(negedge clk);
    run_req(9'd366, 1'b0, -1, n, b0, d0);
    compared++;
    if (n !== 1 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL ill366_lat_err got=%0d/%b want=1/1", n, err);
    end
    compared++;
    if (hexes() !== 32'hBFBF_BFBF) begin
      mismatched++;
      $display("FAIL ill366_hex got=%h want=bfbfbfbf", hexes());
    end
    @(negedge clk);
    run_req(9'd0, 1'b1, -1, n, b0, d0);
    compared++;
    if (n !== 1 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL ill0_lat_err got=%0d/%b want=1/1", n, err);
    end
    compared++;
    if (hexes() !== 32'hBFBF_BFBF) begin
      mismatched++;
      $display("FAIL ill0_hex got=%h want=bfbfbfbf", hexes());
    end
    @(negedge clk);
    run_req(9'd1, 1'b0, -1, n, b0, d0);
    compared++;
    if (n !== 3 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL jan1_lat_err got=%0d/%b want=3/0", n, err);
    end
    compared++;
    if (hexes() !== 32'hFFF9_FFF9) begin
      mismatched++;
      $display("FAIL jan1_hex got=%h want=fff9fff9", hexes());
    end
  endtask

  task automatic test_ignored_start();
    int n;
    logic b0, d0;
    @(negedge clk);
    run_req(9'd300, 1'b0, 3, n, b0, d0);
    compared++;
    if (n !== 14) begin
      mismatched++;
      $display("FAIL oct27_latency got=%0d want=14", n);
    end
    compared++;
    if (hexes() !== 32'hF9C0_A4F8) begin
      mismatched++;
      $display("FAIL oct27_hex got=%h want=f9c0a4f8", hexes());
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, done} !== 2'b00) begin
      mismatched++;
      $display("FAIL oct27_not_queued got=%b%b want=00", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start       = 1'b1;
    day_of_year = 9'd300;
    leap        = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    compared++;
    if (hexes() !== 32'hFFFF_FFFF || {busy, done, err} !== 3'b000) begin
      mismatched++;
      $display("FAIL midreset_clear got=%h/%b want=ffffffff/000",
               hexes(), {busy, done, err});
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
      if (k == 4) reset_n = 1'b1;
    end
    compared++;
    if (seen !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_nodone got=%0d/%b want=0/0", seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic b0, d0;
    @(negedge clk);
    run_req(9'd60, 1'b0, -1, n1, b0, d0);
    run_req(9'd1, 1'b0, -1, n2, b0, d0);
    compared++;
    if (n1 !== 5 || d0 !== 1'b0 || b0 !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_accept got=%0d/%b/%b want=5/0/1", n1, d0, b0);
    end
    compared++;
    if (n2 !== 3 || hexes() !== 32'hFFF9_FFF9) begin
      mismatched++;
      $display("FAIL b2b_second got=%0d/%h want=3/fff9fff9", n2, hexes());
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_mar1();
    test_feb29();
    test_dec31();
    test_illegal();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
